// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback sources, the arbiter and reg_file.
// The slave modport is the arbiter's view. The master modport is the datapath/reg_file side.
interface regfile_wb_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5,
    parameter int CNT_W = 16
);
    localparam int NREGS = 1 << DEPTH;

    logic             hold;
    logic             alu_valid;
    logic [DEPTH-1:0] alu_rd;
    logic [WIDTH-1:0] alu_data;
    logic             alu_ready;
    logic             mem_valid;
    logic [DEPTH-1:0] mem_rd;
    logic [WIDTH-1:0] mem_data;
    logic             mem_ready;
    logic             wr;
    logic [DEPTH-1:0] write_register;
    logic [WIDTH-1:0] write_data;
    logic [NREGS-1:0] pending_mask;
    logic [CNT_W-1:0] contention_cnt;

    modport slave (
        input  hold,
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        output wr, write_register, write_data,
        output pending_mask, contention_cnt
    );

    modport master (
        output hold,
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        input  wr, write_register, write_data,
        input  pending_mask, contention_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the reg_file write port between ALU and load writeback.
// The winner is registered one cycle ahead of the reg_file write. Writes to x0 are dropped.
module regfile_wb_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int NREGS = 1 << DEPTH;

    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_MEM = 1'b1
    } prio_e;

    prio_e            prio_q, prio_d;
    logic             wr_q, wr_d;
    logic [DEPTH-1:0] write_register_q, write_register_d;
    logic [WIDTH-1:0] write_data_q, write_data_d;
    logic [CNT_W-1:0] contention_cnt_q, contention_cnt_d;

    logic grant_alu, grant_mem, accept_ok, contend;
    logic alu_ready, mem_ready;

    always_comb begin
        contend   = bus.alu_valid & bus.mem_valid;
        // Readies stay low while reset is held, so nothing is accepted until it is released.
        accept_ok = ~bus.hold & ~rst;
        grant_alu = bus.alu_valid & (~bus.mem_valid | (prio_q == PRIO_ALU));
        grant_mem = bus.mem_valid & (~bus.alu_valid | (prio_q == PRIO_MEM));
        alu_ready = grant_alu & accept_ok;
        mem_ready = grant_mem & accept_ok;
    end

    always_comb begin
        prio_d           = prio_q;
        wr_d             = 1'b0;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        contention_cnt_d = contention_cnt_q;

        // The side that lost this contention gets priority next time.
        if (contend && accept_ok) begin
            prio_d = grant_alu ? PRIO_MEM : PRIO_ALU;
        end

        if (alu_ready) begin
            write_register_d = bus.alu_rd;
            write_data_d     = bus.alu_data;
            wr_d             = |bus.alu_rd;
        end else if (mem_ready) begin
            write_register_d = bus.mem_rd;
            write_data_d     = bus.mem_data;
            wr_d             = |bus.mem_rd;
        end

        if (contend && !bus.hold && (contention_cnt_q != {CNT_W{1'b1}})) begin
            contention_cnt_d = contention_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q           <= PRIO_ALU;
            wr_q             <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
            contention_cnt_q <= '0;
        end else begin
            prio_q           <= prio_d;
            wr_q             <= wr_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
            contention_cnt_q <= contention_cnt_d;
        end
    end

    assign bus.alu_ready      = alu_ready;
    assign bus.mem_ready      = mem_ready;
    assign bus.wr             = wr_q;
    assign bus.write_register = write_register_q;
    assign bus.write_data     = write_data_q;
    assign bus.contention_cnt = contention_cnt_q;

    // One bit per register so hazard logic can see the in-flight destination.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_pending
            assign bus.pending_mask[gi] = wr_q & (write_register_q == DEPTH'(gi));
        end
    endgenerate

    ap_one_ready: assert property (@(posedge clk) disable iff (rst) !(alu_ready && mem_ready));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter. A reference model pushes the expected write to a scoreboard when
// stimulus is driven, and the entry is popped and checked after the next clock edge.
module tb_regfile_wb_arbiter;
    localparam int WIDTH = 32;
    localparam int DEPTH = 5;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    regfile_wb_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    regfile_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic             wr;
        logic [DEPTH-1:0] rd;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    int               m_prio;
    int               m_cnt;
    logic [DEPTH-1:0] m_reg;
    logic [WIDTH-1:0] m_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_prio = 0;
        m_cnt  = 0;
        m_reg  = '0;
        m_data = '0;
        sb.delete();
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input string tag,
                        input logic av, input logic [DEPTH-1:0] ard, input logic [WIDTH-1:0] adat,
                        input logic mv, input logic [DEPTH-1:0] mrd, input logic [WIDTH-1:0] mdat,
                        input logic hd);
        logic ga, gm, ear, emr;
        exp_t e, got;
        logic [31:0] exp_mask;
        bus.alu_valid = av;  bus.alu_rd = ard;  bus.alu_data = adat;
        bus.mem_valid = mv;  bus.mem_rd = mrd;  bus.mem_data = mdat;
        bus.hold      = hd;
        #1;
        ga  = av & (~mv | (m_prio == 0));
        gm  = mv & (~av | (m_prio == 1));
        ear = ga & ~hd;
        emr = gm & ~hd;
        chk({tag, ".alu_ready"}, 64'(bus.alu_ready), 64'(ear));
        chk({tag, ".mem_ready"}, 64'(bus.mem_ready), 64'(emr));
        e.wr = 1'b0;
        if (ear) begin
            m_reg = ard; m_data = adat; e.wr = (ard != 0);
        end else if (emr) begin
            m_reg = mrd; m_data = mdat; e.wr = (mrd != 0);
        end
        e.rd   = m_reg;
        e.data = m_data;
        sb.push_back(e);
        if (av && mv && !hd) begin
            m_prio = ga ? 1 : 0;
            if (m_cnt != CNT_MAX) m_cnt++;
        end
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 64'd0, 64'd1);
        end else begin
            got = sb.pop_front();
            exp_mask = got.wr ? (32'd1 << got.rd) : 32'd0;
            chk({tag, ".wr"}, 64'(bus.wr), 64'(got.wr));
            chk({tag, ".write_register"}, 64'(bus.write_register), 64'(got.rd));
            chk({tag, ".write_data"}, 64'(bus.write_data), 64'(got.data));
            chk({tag, ".pending_mask"}, 64'(bus.pending_mask), 64'(exp_mask));
        end
        chk({tag, ".contention_cnt"}, 64'(bus.contention_cnt), 64'(m_cnt));
        $display("step %s: alu_v=%0b mem_v=%0b hold=%0b -> wr=%0b reg=%0d data=%0h cnt=%0d",
                 tag, av, mv, hd, bus.wr, bus.write_register, bus.write_data, bus.contention_cnt);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        bus.hold = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h1111;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd2; bus.mem_data = 32'h2222;

        // Reset held with both requesters valid.
        repeat (3) @(posedge clk);
        #1;
        chk("rst.alu_ready", 64'(bus.alu_ready), 64'd0);
        chk("rst.mem_ready", 64'(bus.mem_ready), 64'd0);
        chk("rst.wr", 64'(bus.wr), 64'd0);
        chk("rst.write_register", 64'(bus.write_register), 64'd0);
        chk("rst.write_data", 64'(bus.write_data), 64'd0);
        chk("rst.pending_mask", 64'(bus.pending_mask), 64'd0);
        chk("rst.contention_cnt", 64'(bus.contention_cnt), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel.alu_ready", 64'(bus.alu_ready), 64'd1);
        chk("rel.mem_ready", 64'(bus.mem_ready), 64'd0);
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rel.wr", 64'(bus.wr), 64'd0);

        // Single ALU write.
        step("alu5", 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0);
        chk("alu5.mask", 64'(bus.pending_mask), 64'h20);

        // Four cycles of contention alternate ALU, MEM, ALU, MEM.
        for (int i = 0; i < 4; i++) begin
            step($sformatf("cont%0d", i), 1, 5'd1, 32'hA000 + 32'(i), 1, 5'd2, 32'hB000 + 32'(i), 0);
            chk($sformatf("cont%0d.reg", i), 64'(bus.write_register), (i % 2 == 0) ? 64'd1 : 64'd2);
        end
        chk("cont.cnt4", 64'(bus.contention_cnt), 64'd4);

        // Load into x0 completes the handshake but never writes.
        step("x0", 0, 5'd0, 32'h0, 1, 5'd0, 32'h1234, 0);
        chk("x0.wr", 64'(bus.wr), 64'd0);

        // Hold blocks everything, then ALU goes first on release.
        for (int i = 0; i < 3; i++) begin
            step($sformatf("hold%0d", i), 1, 5'd3, 32'hC0DE, 1, 5'd4, 32'hF00D, 1);
        end
        chk("hold.cnt", 64'(bus.contention_cnt), 64'd4);
        step("unhold", 1, 5'd3, 32'hC0DE, 1, 5'd4, 32'hF00D, 0);
        chk("unhold.reg", 64'(bus.write_register), 64'd3);
        step("unhold2", 0, 5'd3, 32'hC0DE, 1, 5'd4, 32'hF00D, 0);

        // Same destination from both sides back to back: last one wins.
        step("same_a", 1, 5'd9, 32'h0000_00AA, 0, 5'd0, 32'h0, 0);
        step("same_m", 0, 5'd0, 32'h0, 1, 5'd9, 32'h0000_00BB, 0);
        chk("same.data", 64'(bus.write_data), 64'hBB);

        // Counter saturates instead of wrapping.
        for (int i = 0; i < 20; i++) begin
            step($sformatf("sat%0d", i), 1, 5'(10 + i % 4), 32'(i), 1, 5'(20 + i % 4), 32'(100 + i), 0);
        end
        chk("sat.cnt", 64'(bus.contention_cnt), 64'(CNT_MAX));

        // Async reset drops an in-flight write immediately.
        step("pre_rst", 1, 5'd7, 32'h7777_7777, 0, 5'd0, 32'h0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.wr", 64'(bus.wr), 64'd0);
        chk("midrst.mask", 64'(bus.pending_mask), 64'd0);
        chk("midrst.cnt", 64'(bus.contention_cnt), 64'd0);
        chk("midrst.alu_ready", 64'(bus.alu_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("midrst.wr_after_edge", 64'(bus.wr), 64'd0);
        rst = 1'b0;
        model_reset();
        step("recover", 1, 5'd7, 32'h7777_7777, 1, 5'd8, 32'h8888, 0);
        chk("recover.reg", 64'(bus.write_register), 64'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
